// File: rtl/gate_eval_arbiter.sv
// gate_eval_arbiter: round-robin arbiter that shares one y = (a & b) | c evaluator
// among NUM_REQ requesters. Each transaction is IDLE -> GRANT -> DONE -> IDLE.
//
// Ports:
//   clk           - clock, rising-edge active
//   async_reset_n - asynchronous active-low reset
//   req           - per-requester level request
//   op_a/op_b/op_c- per-requester operand bits
//   gnt           - one-hot grant, high for the GRANT cycle
//   done          - one-hot completion pulse, high for the DONE cycle
//   y_out         - evaluation result, meaningful while y_valid is high
//   y_valid       - result strobe, coincident with done
//   busy          - high whenever the FSM is not idle
module gate_eval_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               async_reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op_a,
  input  logic [NUM_REQ-1:0] op_b,
  input  logic [NUM_REQ-1:0] op_c,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               y_out,
  output logic               y_valid,
  output logic               busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] OneLsb = NUM_REQ'(1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDone
  } state_e;

  state_e          state_q;
  logic [IdxW-1:0] winner_q;
  logic [IdxW-1:0] last_winner_q;

  // Round-robin pick: search starts one past the last winner and wraps.
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand_idx;
  logic            pick_found;

  always_comb begin
    pick_idx   = '0;
    cand_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_idx = IdxW'((32'(last_winner_q) + i) % NUM_REQ);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q       <= StIdle;
      winner_q      <= '0;
      last_winner_q <= LastIdx;
      gnt           <= '0;
      done          <= '0;
      y_out         <= 1'b0;
      y_valid       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done    <= '0;
          y_valid <= 1'b0;
          if (pick_found) begin
            winner_q <= pick_idx;
            gnt      <= OneLsb << pick_idx;
            busy     <= 1'b1;
            state_q  <= StGrant;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        StGrant: begin
          gnt           <= '0;
          // The rotation pointer advances whether the transaction completes or aborts.
          last_winner_q <= winner_q;
          if (req[winner_q]) begin
            y_out   <= (op_a[winner_q] & op_b[winner_q]) | op_c[winner_q];
            done    <= OneLsb << winner_q;
            y_valid <= 1'b1;
            state_q <= StDone;
          end else begin
            // Abort: y_out keeps its previous value.
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StDone: begin
          done    <= '0;
          y_valid <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          gnt     <= '0;
          done    <= '0;
          y_valid <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Scoreboard bench for gate_eval_arbiter (NUM_REQ = 3). Stimulus pushes the
// expected grant index and completion result into queues; a negedge monitor
// pops and compares whenever gnt or done/y_valid is presented.
module tb_gate_eval_arbiter;

  localparam int unsigned N = 3;

  logic         clk;
  logic         async_reset_n;
  logic [N-1:0] req;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] op_c;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         y_out;
  logic         y_valid;
  logic         busy;

  int checks = 0;
  int errors = 0;

  int gnt_q[$];
  int done_idx_q[$];
  bit done_y_q[$];

  gate_eval_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .async_reset_n(async_reset_n),
    .req          (req),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_c         (op_c),
    .gnt          (gnt),
    .done         (done),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input int idx, input bit y, input bit completes);
    gnt_q.push_back(idx);
    if (completes) begin
      done_idx_q.push_back(idx);
      done_y_q.push_back(y);
    end
  endtask

  // Hold req for n back-to-back transactions, then release before the next arbitration.
  task automatic run(input logic [N-1:0] r, input int n);
    req = r;
    repeat (3 * n - 1) step();
    req = '0;
    step();
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_y_out"}, 32'(y_out), 32'h0);
    check({tag, "_y_valid"}, 32'(y_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    async_reset_n = 1'b0;
    #1;
    check_outs_zero(tag);
    #2;
    async_reset_n = 1'b1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (async_reset_n) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'h1);
      check("done_onehot0", 32'($onehot0(done)), 32'h1);
      check("gnt_done_excl", 32'((|gnt) && (|done)), 32'h0);
      check("busy", 32'(busy), 32'((|gnt) || (|done)));
      check("y_valid_eq_done", 32'(y_valid), 32'(|done));
      if (|gnt) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 32'(gnt), 32'h0);
        end else begin
          int gi;
          gi = gnt_q.pop_front();
          check("gnt_order", 32'(gnt), 32'(1) << gi);
        end
      end
      if ((|done) || y_valid) begin
        if (done_idx_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'h0);
        end else begin
          int  di;
          bit  dy;
          di = done_idx_q.pop_front();
          dy = done_y_q.pop_front();
          check("done_vec", 32'(done), 32'(1) << di);
          check("y_out", 32'(y_out), 32'(dy));
        end
      end
    end
  end

  initial begin
    req           = '0;
    op_a          = '0;
    op_b          = '0;
    op_c          = '0;
    async_reset_n = 1'b0;
    #2;
    check_outs_zero("reset_init");
    #2;
    async_reset_n = 1'b1;
    step();

    // Single requester: y = (1&1)|0 = 1
    op_a = 3'b001; op_b = 3'b001; op_c = 3'b000;
    expect_txn(0, 1'b1, 1'b1);
    run(3'b001, 1);
    step();

    // Contention after reset: order 0,1,2,0; y = (0&1)|0 = 0
    do_reset("reset_a");
    op_a = 3'b000; op_b = 3'b111; op_c = 3'b000;
    expect_txn(0, 1'b0, 1'b1);
    expect_txn(1, 1'b0, 1'b1);
    expect_txn(2, 1'b0, 1'b1);
    expect_txn(0, 1'b0, 1'b1);
    run(3'b111, 4);
    step();

    // Fairness: 0,2,0,2; y = 1
    do_reset("reset_b");
    op_a = 3'b111; op_b = 3'b111; op_c = 3'b000;
    expect_txn(0, 1'b1, 1'b1);
    expect_txn(2, 1'b1, 1'b1);
    expect_txn(0, 1'b1, 1'b1);
    expect_txn(2, 1'b1, 1'b1);
    run(3'b101, 4);
    step();

    // Abort of requester 1; operands would give y=1, so y_out must stay 0
    do_reset("reset_c");
    op_a = 3'b010; op_b = 3'b010; op_c = 3'b000;
    expect_txn(1, 1'b0, 1'b0);
    req = 3'b010;
    step();
    req = 3'b000;
    step();
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_y_out_kept", 32'(y_out), 32'h0);
    check("abort_no_valid", 32'(y_valid), 32'h0);
    // Search starts at 2 (not requesting), wraps to 0; y0 = (0&0)|1 = 1
    op_c = 3'b001;
    expect_txn(0, 1'b1, 1'b1);
    run(3'b011, 1);
    step();

    // Reset while in DONE: no done is ever sampled, pointer restored
    do_reset("reset_d");
    op_a = 3'b001; op_b = 3'b001; op_c = 3'b000;
    expect_txn(0, 1'b1, 1'b0);
    req = 3'b001;
    step();
    step();
    req = 3'b000;
    check("pre_reset_in_done", 32'(y_valid), 32'h1);
    do_reset("reset_mid_done");
    // y1 = (1&0)|1 = 1
    op_a = 3'b011; op_b = 3'b001; op_c = 3'b010;
    expect_txn(1, 1'b1, 1'b1);
    run(3'b110, 1);
    step();

    // Truth table through requester 2; non-winner operands hold the inverse
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      bit a, b, c;
      v = 3'(i);
      a = v[2];
      b = v[1];
      c = v[0];
      op_a = {a, {2{~a}}};
      op_b = {b, {2{~b}}};
      op_c = {c, {2{~c}}};
      expect_txn(2, (a & b) | c, 1'b1);
      run(3'b100, 1);
    end

    repeat (3) step();
    check("gnt_q_drained", 32'(gnt_q.size()), 32'h0);
    check("done_q_drained", 32'(done_idx_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_eval_arbiter.md
GATE_EVAL_ARBITER -- requirements
Module: gate_eval_arbiter

Interface
REQ-001 The block SHALL provide parameter NUM_REQ, default 3, number of requesters, legal range 2..8.
REQ-002 The block SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port async_reset_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL provide port req, input, NUM_REQ, per-requester evaluation request, level.
REQ-005 The block SHALL provide ports op_a, op_b, op_c, input, NUM_REQ each, per-requester operand bits.
REQ-006 The block SHALL provide port gnt, output, NUM_REQ, one-hot grant, registered.
REQ-007 The block SHALL provide port done, output, NUM_REQ, one-hot completion pulse, registered.
REQ-008 The block SHALL provide port y_out, output, 1, evaluation result, valid only while y_valid=1.
REQ-009 The block SHALL provide port y_valid, output, 1, result-valid strobe, coincident with done.
REQ-010 The block SHALL provide port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 The block SHALL share one evaluation unit computing y = (a & b) | c among NUM_REQ requesters.
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, DONE.
REQ-013 IDLE with req==0 SHALL remain in IDLE, with gnt, done and y_valid all 0.
REQ-014 IDLE with req!=0 at rising edge t SHALL select a winner round-robin and enter GRANT.
REQ-015 In GRANT, gnt SHALL equal the winner's one-hot vector from t+1.
REQ-016 Round-robin search SHALL begin at index (last_winner+1) mod NUM_REQ and ascend, wrapping at NUM_REQ-1 to 0.
REQ-017 After reset, last_winner SHALL equal NUM_REQ-1, so requester 0 has highest priority first.
REQ-018 In GRANT, if req[winner]=1 at the edge, the block SHALL register {op_a,op_b,op_c}[winner], compute y into y_out, and enter DONE.
REQ-019 In GRANT, if req[winner]=0 at the edge (abort), the block SHALL return to IDLE, assert no done, leave y_out unchanged, and update last_winner.
REQ-020 In DONE, for exactly one cycle, done[winner]=1, y_valid=1 and gnt=0.
REQ-021 DONE SHALL always transition to IDLE on the next edge.
REQ-022 last_winner SHALL update on the GRANT exit edge in both the complete and abort cases.
REQ-023 Latency SHALL be: req sampled at edge t, gnt visible t..t+1, done/y_valid t+1..t+2, IDLE again at t+2.
REQ-024 Peak throughput SHALL be one transaction per 3 cycles; a held req SHALL re-arbitrate in the next IDLE cycle.
REQ-025 Operand or req changes of non-winners during GRANT/DONE SHALL have no effect on the current transaction.
REQ-026 A requester asserting req during busy SHALL be considered at the next IDLE arbitration.
REQ-027 gnt and done SHALL never have more than one bit set, and SHALL never both be nonzero in the same cycle.

Reset
REQ-028 async_reset_n=0 SHALL immediately force state to IDLE and clear gnt, done, y_out, y_valid and busy, independent of clk.
REQ-029 Reset during GRANT or DONE SHALL abort the transaction with no done pulse and SHALL restore last_winner to NUM_REQ-1.
REQ-030 Reset deassertion SHALL take effect at the next rising clk edge; the first arbitration SHALL be possible on that edge.

Verification
REQ-031 Single requester: req=3'b001 with a0=1, b0=1, c0=0 -> gnt=001 for 1 cycle, then done=001, y_valid=1, y_out=1.
REQ-032 Contention: req=3'b111 held -> grant order 0,1,2,0; operands a=0, b=1, c=0 on all requesters -> y_out=0 each time.
REQ-033 Fairness: req=3'b101 held after reset -> grants alternate 0,2,0,2; requester 1 never granted.
REQ-034 Abort: req[1] dropped during GRANT -> no done; IDLE next cycle; a following request from 0 and 1 grants 2-priority order starting at index 2.
REQ-035 Reset mid-DONE: assert async_reset_n=0 between edges -> outputs 0 immediately; after release, req=3'b110 grants 1 first.
REQ-036 Truth table: sweep all 8 {a,b,c} combinations via requester 2 -> y_out matches (a&b)|c on each.
